// File: rtl/ad_frame_pkg.sv
// Shared definitions for the ADC/test-pattern framer: word layout, magics,
// output FSM encoding and helpers that build each kind of frame word.
// Optional trailer/checksum support is selected by the AD_FRAME_CRC_EN macro.
package ad_frame_pkg;

  localparam int WORD_W  = 32;
  localparam int SAMP_W  = 24;
  localparam int ENTRY_W = SAMP_W + 1;   // sample plus source tag

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam logic [7:0] TLR_MAGIC = 8'h5A;

`ifdef AD_FRAME_CRC_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2
  } state_t;
`endif

  // FIFO entry: tag=1 marks a test-pattern sample
  typedef struct packed {
    logic              tag;
    logic [SAMP_W-1:0] sample;
  } entry_t;

  function automatic logic [WORD_W-1:0] head_word(input logic [7:0] seq,
                                                  input logic [7:0] len);
    return {HDR_MAGIC, seq, len, 8'h00};
  endfunction

  function automatic logic [WORD_W-1:0] data_word(input entry_t e);
    return {7'h00, e.tag, e.sample};
  endfunction

  function automatic logic [WORD_W-1:0] tail_word(input logic [7:0]  seq,
                                                  input logic [15:0] csum);
    return {TLR_MAGIC, seq, csum};
  endfunction

endpackage

// File: rtl/ad_frame_fifo.sv
// Show-ahead sample FIFO: the head entry is visible on rd_data whenever
// empty is low. A write while full is taken only if a pop happens the
// same cycle, so a full FIFO being drained still accepts a new sample.
module ad_frame_fifo #(
  parameter int AW = 4,
  parameter int DW = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push;
  logic          pop;

  // extra pointer MSB distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // pointer update; both may move in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage array, no reset needed since empty gates every read use
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ad_frame.sv
// ADC / test-pattern sample framer. Selected samples are tagged and queued
// in a FIFO; the output FSM wraps them into frames of cfg_frm_len samples
// (0 = 256): a header word, the data words, and with AD_FRAME_CRC_EN defined
// a trailer carrying a 16-bit sum of the frame's samples.
module ad_frame
  import ad_frame_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [SAMP_W-1:0] ad_data,
  input  logic              ad_vld,
  input  logic [SAMP_W-1:0] tp_data,
  input  logic              tp_vld,
  input  logic [7:0]        cfg_ad_tp,
  input  logic [7:0]        cfg_frm_len,
  output logic [WORD_W-1:0] frm_data,
  output logic              frm_vld,
  input  logic              frm_rdy,
  output logic              frm_sop,
  output logic              frm_eop,
  output logic [7:0]        ovf_cnt
);

  state_t             state;
  state_t             nxt;
  logic               sel_tp;
  logic               sel_vld;
  entry_t             sel_entry;
  logic [ENTRY_W-1:0] rd_data;
  entry_t             head;
  logic               full;
  logic               empty;
  logic               pop;
  logic               wr;
  logic               drop;
  logic               last;
  logic               seq_inc;
  logic [7:0]         seq;
  logic [7:0]         len_q;
  logic [7:0]         cnt;

  // source select is purely combinational, so it can change per sample
  assign sel_tp    = |cfg_ad_tp;
  assign sel_vld   = sel_tp ? tp_vld : ad_vld;
  assign sel_entry = sel_tp ? entry_t'({1'b1, tp_data}) : entry_t'({1'b0, ad_data});

  // a pop frees a slot in the same cycle, so full+pop still accepts
  assign pop  = (state == ST_DATA) && !empty && frm_rdy;
  assign wr   = sel_vld && (!full || pop);
  assign drop = sel_vld && full && !pop;
  assign head = entry_t'(rd_data);

  // 8-bit compare: a latched length of 0 ends the frame at count 255
  assign last = (cnt == len_q - 8'd1);

  ad_frame_fifo #(
    .AW (FIFO_AW),
    .DW (ENTRY_W)
  ) u_fifo (
    .clk     (clk_sys),
    .rst_n   (rst_n),
    .wr_en   (wr),
    .wr_data (sel_entry),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  // dropped-sample counter, sticks at all-ones
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                         ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF)  ovf_cnt <= ovf_cnt + 8'd1;
  end

  // output FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // frame context: length latched at frame start so later cfg edits wait
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt   <= '0;
      seq   <= '0;
    end else begin
      if (state == ST_IDLE && !empty) begin
        len_q <= cfg_frm_len;
        cnt   <= '0;
      end else if (pop) begin
        cnt <= cnt + 8'd1;
      end
      if (seq_inc) seq <= seq + 8'd1;
    end
  end

`ifdef AD_FRAME_CRC_EN
  logic [15:0] csum;

  // running checksum of the current frame, low 16 bits of each sample
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                          csum <= '0;
    else if (state == ST_IDLE && !empty) csum <= '0;
    else if (pop)                        csum <= csum + head.sample[15:0];
  end
`endif

  // next-state and frame word generation; outputs depend only on state and
  // FIFO head, so they hold steady while the sink stalls
  always_comb begin
    nxt      = state;
    frm_vld  = 1'b0;
    frm_sop  = 1'b0;
    frm_eop  = 1'b0;
    frm_data = '0;
    seq_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) nxt = ST_HEAD;
      end
      ST_HEAD: begin
        frm_vld  = 1'b1;
        frm_sop  = 1'b1;
        frm_data = head_word(seq, len_q);
        if (frm_rdy) nxt = ST_DATA;
      end
      ST_DATA: begin
        frm_vld = !empty;
        if (!empty) frm_data = data_word(head);
`ifdef AD_FRAME_CRC_EN
        if (pop && last) nxt = ST_TAIL;
`else
        frm_eop = !empty && last;
        if (pop && last) begin
          nxt     = ST_IDLE;
          seq_inc = 1'b1;
        end
`endif
      end
`ifdef AD_FRAME_CRC_EN
      ST_TAIL: begin
        frm_vld  = 1'b1;
        frm_eop  = 1'b1;
        frm_data = tail_word(seq, csum);
        if (frm_rdy) begin
          nxt     = ST_IDLE;
          seq_inc = 1'b1;
        end
      end
`endif
      default: nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ad_frame.sv
// Testbench for ad_frame: a cycle table for the basic frame, directed
// sequences for overflow, reset and config corners, and randomized traffic
// checked against a queue-based frame model. Honours AD_FRAME_CRC_EN.
module tb_ad_frame;

`ifdef AD_FRAME_CRC_EN
  localparam bit CRC = 1'b1;
`else
  localparam bit CRC = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [23:0] ad_data = '0;
  logic        ad_vld  = 1'b0;
  logic [23:0] tp_data = '0;
  logic        tp_vld  = 1'b0;
  logic [7:0]  cfg_ad_tp   = '0;
  logic [7:0]  cfg_frm_len = '0;
  logic [31:0] frm_data;
  logic        frm_vld;
  logic        frm_rdy = 1'b0;
  logic        frm_sop;
  logic        frm_eop;
  logic [7:0]  ovf_cnt;

  ad_frame #(.FIFO_AW(4)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .ad_data     (ad_data),
    .ad_vld      (ad_vld),
    .tp_data     (tp_data),
    .tp_vld      (tp_vld),
    .cfg_ad_tp   (cfg_ad_tp),
    .cfg_frm_len (cfg_frm_len),
    .frm_data    (frm_data),
    .frm_vld     (frm_vld),
    .frm_rdy     (frm_rdy),
    .frm_sop     (frm_sop),
    .frm_eop     (frm_eop),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: queue mirrors the samples held for output
  logic [24:0] mq[$];
  int          m_phase;      // 0 expect header, 1 data, 2 trailer
  int          m_rem;
  int          m_ndata;
  logic [7:0]  m_seq;
  logic [7:0]  m_drop;
  logic [15:0] m_csum;
  logic [7:0]  cur_len;
  bit          mon_en;
  bit          prev_stall;
  logic [33:0] prev_word;

  typedef struct {
    logic        tv;
    logic [23:0] td;
    logic        ev;
    logic [31:0] ed;
    logic        es;
    logic        ee;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_rem = 0; m_ndata = 0;
    m_seq = 8'h00; m_drop = 8'h00; m_csum = 16'h0;
    prev_stall = 1'b0; prev_word = '0;
  endtask

  // one clock edge worth of model behaviour, evaluated at the negedge
  task automatic monitor();
    logic [31:0] ew;
    logic        es, ee, sv, last;
    logic [24:0] sd;
    if (prev_stall && frm_vld)
      chk("stall_stable", {frm_data, frm_sop, frm_eop}, prev_word);
    if (frm_vld && frm_rdy) begin
      ew = '0; es = 1'b0; ee = 1'b0;
      if (m_phase == 0) begin
        ew = {8'hA5, m_seq, cur_len, 8'h00}; es = 1'b1;
        m_phase = 1; m_rem = (cur_len == 0) ? 256 : int'(cur_len); m_csum = 16'h0;
      end else if (m_phase == 1) begin
        if (mq.size() == 0) begin
          chk("xfer_with_no_sample", 1, 0);
        end else begin
          ew = {7'h0, mq[0]};
          last = (m_rem == 1);
          ee = last && !CRC;
          m_csum = m_csum + mq[0][15:0];
          void'(mq.pop_front());
          m_rem--; m_ndata++;
          if (last) begin
            if (CRC) m_phase = 2;
            else begin m_phase = 0; m_seq++; end
          end
        end
      end else begin
        ew = {8'h5A, m_seq, m_csum}; ee = 1'b1;
        m_phase = 0; m_seq++;
      end
      chk("word", frm_data, ew);
      chk("sop", frm_sop, es);
      chk("eop", frm_eop, ee);
    end
    prev_stall = frm_vld && !frm_rdy;
    prev_word  = {frm_data, frm_sop, frm_eop};
    sv = (cfg_ad_tp != 0) ? tp_vld : ad_vld;
    sd = (cfg_ad_tp != 0) ? {1'b1, tp_data} : {1'b0, ad_data};
    if (sv) begin
      if (mq.size() < 16) mq.push_back(sd);
      else if (m_drop != 8'hFF) m_drop++;
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
    if (mon_en) monitor();
    @(posedge clk_sys); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ad_vld = 1'b0; tp_vld = 1'b0; frm_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_vld", frm_vld, 0);
    chk("rst_sop", frm_sop, 0);
    chk("rst_eop", frm_eop, 0);
    chk("rst_data", frm_data, 0);
    chk("rst_ovf", ovf_cnt, 0);
    rst_n = 1'b1;
  endtask

  // finish any open frame, feeding just enough samples to close it
  task automatic drain();
    int k = 0;
    ad_vld = 1'b0; tp_vld = 1'b0; frm_rdy = 1'b1;
    while (!(m_phase == 0 && mq.size() == 0) && k < 3000) begin
      ad_vld = 1'b0; tp_vld = 1'b0;
      if (m_phase == 1 && mq.size() < m_rem) begin
        if (cfg_ad_tp != 0) begin tp_vld = 1'b1; tp_data = 24'($urandom); end
        else begin ad_vld = 1'b1; ad_data = 24'($urandom); end
      end
      step();
      k++;
    end
    ad_vld = 1'b0; tp_vld = 1'b0;
    chk("drain_in_budget", k < 3000, 1);
    repeat (3) step();
    chk("idle_quiet", frm_vld, 0);
  endtask

  task automatic run_rand(input int n, input logic [7:0] len, input int src,
                          input int vld_pct, input int rdy_mode);
    cfg_frm_len = len; cur_len = len;
    for (int c = 0; c < n; c++) begin
      ad_vld  = ($urandom_range(99) < vld_pct);
      tp_vld  = ($urandom_range(99) < vld_pct);
      ad_data = 24'($urandom);
      tp_data = 24'($urandom);
      case (src)
        0: cfg_ad_tp = 8'h00;
        1: cfg_ad_tp = 8'($urandom_range(255, 1));
        default: cfg_ad_tp = $urandom_range(1) ? 8'h00 : 8'($urandom_range(255, 1));
      endcase
      case (rdy_mode)
        0: frm_rdy = $urandom_range(1);
        1: frm_rdy = ~frm_rdy;
        2: frm_rdy = ($urandom_range(99) < 90);
        default: frm_rdy = ($urandom_range(99) < 30);
      endcase
      step();
    end
    drain();
    chk("ovf_vs_model", ovf_cnt, m_drop);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic frame: len 4, test pattern, sink always ready
    tbl[0] = '{1'b1, 24'h10, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 24'h20, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 24'h30, 1'b1, 32'hA500_0400, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 24'h40, 1'b1, 32'h0100_0010, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 24'h0,  1'b1, 32'h0100_0020, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 24'h0,  1'b1, 32'h0100_0030, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 24'h0,  1'b1, 32'h0100_0040, 1'b0, !CRC};
    if (CRC) tbl[7] = '{1'b1, 24'h50, 1'b1, 32'h5A00_00A0, 1'b0, 1'b1};
    else     tbl[7] = '{1'b1, 24'h50, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 24'h0,  1'b0, 32'h0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 24'h0,  1'b1, 32'hA501_0400, 1'b1, 1'b0};

    mon_en = 1'b0;
    cfg_ad_tp = 8'h01; cfg_frm_len = 8'd4;
    @(posedge clk_sys); #1;
    do_reset();
    frm_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tp_vld = tbl[i].tv; tp_data = tbl[i].td;
      @(negedge clk_sys);
      chk($sformatf("tbl%0d_vld", i), frm_vld, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), frm_data, tbl[i].ed);
        chk($sformatf("tbl%0d_sop", i), frm_sop, tbl[i].es);
        chk($sformatf("tbl%0d_eop", i), frm_eop, tbl[i].ee);
      end
      @(posedge clk_sys); #1;
    end

    // reset in the middle of a frame discards it; numbering restarts at 0
    do_reset();
    frm_rdy = 1'b1;
    tp_vld = 1'b1; tp_data = 24'h111; step();
    tp_data = 24'h222; step();
    tp_vld = 1'b0; step();
    @(negedge clk_sys);
    chk("pre_rst_data", frm_data, 32'h0100_0111);
    @(posedge clk_sys); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", frm_vld, 0);
    chk("mid_rst_data", frm_data, 0);
    @(posedge clk_sys); #1;
    chk("mid_rst_edge_vld", frm_vld, 0);
    chk("mid_rst_edge_eop", frm_eop, 0);
    rst_n = 1'b1;
    tp_vld = 1'b1; tp_data = 24'h333; step();
    tp_vld = 1'b0; step();
    @(negedge clk_sys);
    chk("post_rst_vld", frm_vld, 1);
    chk("post_rst_hdr", frm_data, 32'hA500_0400);
    @(posedge clk_sys); #1;

    // overflow: 20 back-to-back samples into a stalled sink
    do_reset();
    mon_en = 1'b1;
    cfg_ad_tp = 8'h00; cfg_frm_len = 8'd16; cur_len = 8'd16;
    frm_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ad_vld = 1'b1; ad_data = 24'(i + 1); step();
    end
    ad_vld = 1'b0; step();
    chk("ovf_after_20", ovf_cnt, 8'd4);
    m_ndata = 0;
    drain();
    chk("ovf_frame_words", m_ndata, 16);

    // drop counter saturates
    frm_rdy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ad_vld = 1'b1; ad_data = 24'($urandom); step();
    end
    ad_vld = 1'b0; step();
    chk("ovf_saturated", ovf_cnt, 8'hFF);
    drain();

    // length change after frame start waits for the next frame
    do_reset();
    cfg_ad_tp = 8'h01; cfg_frm_len = 8'd4; cur_len = 8'd4; frm_rdy = 1'b1;
    tp_vld = 1'b1; tp_data = 24'hABC; step();
    tp_data = 24'hDEF; step();
    tp_vld = 1'b0; repeat (4) step();
    cfg_frm_len = 8'd9;
    drain();

    // checksum carry wraps (trailer only in the CRC build)
    cfg_frm_len = 8'd2; cur_len = 8'd2;
    tp_vld = 1'b1; tp_data = 24'h00FFFF; step();
    tp_data = 24'h000002; step();
    tp_vld = 1'b0;
    drain();

    // randomized traffic against the model
    run_rand(300, 8'd5, 1, 60, 0);
    run_rand(400, 8'd3, 0, 70, 1);
    run_rand(700, 8'd0, 2, 90, 2);
    run_rand(300, 8'd1, 2, 90, 3);
    run_rand(300, 8'd9, 0, 40, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
